// File: rtl/avmm_rw_responder.sv
// avmm_rw_responder: Avalon-MM agent memory for the 64-bit HLS read/write host port.
// Fixed read latency (READ_LATENCY), write-first host port, backdoor preload/inspect
// port and saturating access counters.
// Optional feature: define AVMM_RESP_RANGE_CHECK_EN to reject out-of-range or
// misaligned accesses and expose the sticky range_err flag.
module avmm_rw_responder #(
  parameter int unsigned DEPTH        = 1024,
  parameter logic [63:0] BASE_ADDR    = 64'h0,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [63:0]              avmm_address,
  input  logic [7:0]               avmm_byteenable,
  input  logic                     avmm_read,
  output logic [63:0]              avmm_readdata,
  output logic                     avmm_readdatavalid,
  input  logic                     avmm_write,
  input  logic [63:0]              avmm_writedata,
  input  logic                     dbg_we,
  input  logic [$clog2(DEPTH)-1:0] dbg_index,
  input  logic [63:0]              dbg_wdata,
  output logic [63:0]              dbg_rdata,
  output logic [31:0]              rd_count,
  output logic [31:0]              wr_count
`ifdef AVMM_RESP_RANGE_CHECK_EN
  ,
  output logic                     range_err
`endif
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [63:0]                         mem_q [DEPTH];
  logic [IDX_W-1:0]                    word_idx_c;
  logic                                oor_c;
  logic                                rd_acc_c;
  logic                                wr_acc_c;
  logic                                wr_mem_c;
  logic [63:0]                         rd_word_c;

  logic [READ_LATENCY-1:0]             pv_q, pv_d;
  logic [READ_LATENCY-1:0][63:0]       pd_q, pd_d;
  logic [63:0]                         dbg_rdata_q;
  logic [31:0]                         rd_count_q, rd_count_d;
  logic [31:0]                         wr_count_q, wr_count_d;
  logic                                range_err_q, range_err_d;

  assign word_idx_c = IDX_W'((avmm_address - BASE_ADDR) >> 3);

`ifdef AVMM_RESP_RANGE_CHECK_EN
  localparam logic [63:0] END_ADDR = BASE_ADDR + 64'(DEPTH) * 64'd8;
  assign oor_c = (avmm_address < BASE_ADDR) || (avmm_address >= END_ADDR) ||
                 (avmm_address[2:0] != 3'd0);
  assign range_err = range_err_q;
`else
  assign oor_c = 1'b0;
`endif

  assign rd_acc_c = avmm_read  && !reset;
  assign wr_acc_c = avmm_write && !reset;
  assign wr_mem_c = wr_acc_c && !oor_c;

  // Read word with this cycle's masked host write forwarded (write-first).
  always_comb begin
    rd_word_c = mem_q[word_idx_c];
    for (int i = 0; i < 8; i++) begin
      if (wr_mem_c && avmm_byteenable[i]) rd_word_c[8*i +: 8] = avmm_writedata[8*i +: 8];
    end
    if (oor_c) rd_word_c = '0;
  end

  // Storage: backdoor write first, host bytes override it on a shared word.
  always_ff @(posedge clock) begin
    if (dbg_we) mem_q[dbg_index] <= dbg_wdata;
    if (wr_mem_c) begin
      for (int i = 0; i < 8; i++) begin
        if (avmm_byteenable[i]) mem_q[word_idx_c][8*i +: 8] <= avmm_writedata[8*i +: 8];
      end
    end
  end

  // Read pipeline shift; the final data stage only loads on a valid result.
  always_comb begin
    pv_d    = pv_q;
    pd_d    = pd_q;
    pv_d[0] = rd_acc_c;
    pd_d[0] = rd_word_c;
    for (int k = 1; k < int'(READ_LATENCY); k++) begin
      pv_d[k] = pv_q[k-1];
      pd_d[k] = pd_q[k-1];
    end
    if (!pv_d[READ_LATENCY-1]) pd_d[READ_LATENCY-1] = pd_q[READ_LATENCY-1];
  end

  // Saturating counters and sticky range flag.
  always_comb begin
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    range_err_d = range_err_q;
    if (rd_acc_c && (rd_count_q != CNT_MAX)) rd_count_d = rd_count_q + 32'd1;
    if (wr_acc_c && (wr_count_q != CNT_MAX)) wr_count_d = wr_count_q + 32'd1;
    if ((rd_acc_c || wr_acc_c) && oor_c) range_err_d = 1'b1;
  end

  // Control and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pv_q        <= '0;
      pd_q        <= '0;
      dbg_rdata_q <= '0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      range_err_q <= 1'b0;
    end else begin
      pv_q        <= pv_d;
      pd_q        <= pd_d;
      dbg_rdata_q <= mem_q[dbg_index];
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      range_err_q <= range_err_d;
    end
  end

  assign avmm_readdata      = pd_q[READ_LATENCY-1];
  assign avmm_readdatavalid = pv_q[READ_LATENCY-1];
  assign dbg_rdata          = dbg_rdata_q;
  assign rd_count           = rd_count_q;
  assign wr_count           = wr_count_q;

endmodule

// File: tb/tb_avmm_rw_responder.sv
// Bench for avmm_rw_responder: directed scenarios plus randomized traffic checked
// against a word-array memory model with a queue of timed read results.
module tb_avmm_rw_responder;

  localparam int unsigned DEPTH = 1024;
  localparam logic [63:0] BASE  = 64'h0000_0000_0001_0000;
  localparam int unsigned LAT   = 2;

  logic        clock;
  logic        reset;
  logic [63:0] avmm_address;
  logic [7:0]  avmm_byteenable;
  logic        avmm_read;
  logic [63:0] avmm_readdata;
  logic        avmm_readdatavalid;
  logic        avmm_write;
  logic [63:0] avmm_writedata;
  logic        dbg_we;
  logic [9:0]  dbg_index;
  logic [63:0] dbg_wdata;
  logic [63:0] dbg_rdata;
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`ifdef AVMM_RESP_RANGE_CHECK_EN
  logic        range_err;
`else
  logic        range_err;
  assign range_err = 1'b0;
`endif

  avmm_rw_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .avmm_address(avmm_address), .avmm_byteenable(avmm_byteenable),
    .avmm_read(avmm_read), .avmm_readdata(avmm_readdata),
    .avmm_readdatavalid(avmm_readdatavalid),
    .avmm_write(avmm_write), .avmm_writedata(avmm_writedata),
    .dbg_we(dbg_we), .dbg_index(dbg_index), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata),
    .rd_count(rd_count), .wr_count(wr_count)
`ifdef AVMM_RESP_RANGE_CHECK_EN
    , .range_err(range_err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state.
  logic [63:0] ref_mem [DEPTH];
  int          pend_due[$];
  logic [63:0] pend_data[$];
  int          cyc;
  logic        exp_v;
  logic [63:0] m_rdata, m_dbg;
  logic [31:0] m_rd, m_wr;
  logic        m_err;
  int          checks, errors;

  function automatic int unsigned idx_of(input logic [63:0] a);
    return int'(((a - BASE) >> 3) % 64'(DEPTH));
  endfunction

  function automatic bit oor_of(input logic [63:0] a);
`ifdef AVMM_RESP_RANGE_CHECK_EN
    return (a < BASE) || (a >= BASE + 64'(DEPTH) * 64'd8) || (a[2:0] != 3'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle();
    avmm_read = 1'b0; avmm_write = 1'b0; dbg_we = 1'b0;
  endtask

  // Advance one clock; the model absorbs what the DUT accepts on this edge.
  task automatic step();
    int unsigned hi;
    bit          bad;
    logic [63:0] rw;
    cyc++;
    hi  = idx_of(avmm_address);
    bad = oor_of(avmm_address);
    if (reset) begin
      pend_due.delete(); pend_data.delete();
      m_rdata = '0; m_dbg = '0; m_rd = '0; m_wr = '0; m_err = 1'b0;
    end else begin
      m_dbg = ref_mem[dbg_index];
      if (avmm_read) begin
        rw = ref_mem[hi];
        if (avmm_write && !bad)
          for (int b = 0; b < 8; b++) if (avmm_byteenable[b]) rw[8*b +: 8] = avmm_writedata[8*b +: 8];
        if (bad) rw = '0;
        pend_due.push_back(cyc + int'(LAT) - 1);
        pend_data.push_back(rw);
        if (m_rd != 32'hFFFF_FFFF) m_rd++;
      end
      if (avmm_write && m_wr != 32'hFFFF_FFFF) m_wr++;
      if ((avmm_read || avmm_write) && bad) m_err = 1'b1;
    end
    if (dbg_we) ref_mem[dbg_index] = dbg_wdata;
    if (!reset && avmm_write && !bad)
      for (int b = 0; b < 8; b++) if (avmm_byteenable[b]) ref_mem[hi][8*b +: 8] = avmm_writedata[8*b +: 8];
    @(posedge clock);
    #1;
    exp_v = 1'b0;
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      exp_v   = 1'b1;
      m_rdata = pend_data.pop_front();
      void'(pend_due.pop_front());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; idle();
    step(); step();
    checks++; if (avmm_readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", avmm_readdatavalid); end
    checks++; if (avmm_readdata !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", avmm_readdata); end
    checks++; if (dbg_rdata !== 64'h0) begin errors++; $display("FAIL reset_dbg: got %h expected 0", dbg_rdata); end
    checks++; if (rd_count !== 32'd0) begin errors++; $display("FAIL reset_rdcnt: got %0d expected 0", rd_count); end
    checks++; if (wr_count !== 32'd0) begin errors++; $display("FAIL reset_wrcnt: got %0d expected 0", wr_count); end
    checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", range_err); end
    reset = 1'b0;
  endtask

  task automatic preload();
    for (int i = 0; i < int'(DEPTH); i++) begin
      dbg_we = 1'b1; dbg_index = 10'(i); dbg_wdata = {$urandom, $urandom};
      step();
    end
    idle();
  endtask

  task automatic test_single_rw();
    reset = 1'b1; idle(); step(); reset = 1'b0;
    avmm_write = 1'b1; avmm_address = BASE + 64'h18;
    avmm_writedata = 64'h1122334455667788; avmm_byteenable = 8'hFF;
    step();
    avmm_write = 1'b0; avmm_read = 1'b1;
    step();
    checks++; if (avmm_readdatavalid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0b expected 0", avmm_readdatavalid); end
    avmm_read = 1'b0;
    step();
    checks++; if (avmm_readdatavalid !== 1'b1 || avmm_readdata !== 64'h1122334455667788) begin
      errors++; $display("FAIL single_read: got v=%0b d=%h expected v=1 d=1122334455667788", avmm_readdatavalid, avmm_readdata); end
    checks++; if (rd_count !== 32'd1 || wr_count !== 32'd1) begin
      errors++; $display("FAIL single_counts: got rd=%0d wr=%0d expected 1 1", rd_count, wr_count); end
    step();
    checks++; if (avmm_readdatavalid !== 1'b0 || avmm_readdata !== 64'h1122334455667788) begin
      errors++; $display("FAIL single_hold: got v=%0b d=%h expected v=0 d=1122334455667788", avmm_readdatavalid, avmm_readdata); end
  endtask

  task automatic test_byte_mask();
    dbg_we = 1'b1; dbg_index = 10'd3; dbg_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    dbg_we = 1'b0;
    avmm_write = 1'b1; avmm_address = BASE + 64'd24; avmm_writedata = 64'h0; avmm_byteenable = 8'h0F;
    step();
    avmm_write = 1'b0; avmm_read = 1'b1; avmm_byteenable = 8'h00;
    step();
    avmm_read = 1'b0;
    step();
    checks++; if (avmm_readdatavalid !== 1'b1 || avmm_readdata !== 64'hFFFF_FFFF_0000_0000) begin
      errors++; $display("FAIL byte_mask: got v=%0b d=%h expected v=1 d=ffffffff00000000", avmm_readdatavalid, avmm_readdata); end
  endtask

  task automatic test_burst();
    for (int i = 0; i < 8; i++) begin
      dbg_we = 1'b1; dbg_index = 10'(i); dbg_wdata = 64'(i);
      step();
    end
    dbg_we = 1'b0;
    for (int k = 0; k < 10; k++) begin
      avmm_read = (k < 8);
      avmm_address = BASE + 64'(k) * 64'd8;
      step();
      if (k >= 1 && k <= 8) begin
        checks++; if (avmm_readdatavalid !== 1'b1 || avmm_readdata !== 64'(k - 1)) begin
          errors++; $display("FAIL burst_%0d: got v=%0b d=%h expected v=1 d=%h", k, avmm_readdatavalid, avmm_readdata, 64'(k - 1)); end
      end else begin
        checks++; if (avmm_readdatavalid !== 1'b0) begin
          errors++; $display("FAIL burst_edge_%0d: got v=%0b expected 0", k, avmm_readdatavalid); end
      end
    end
  endtask

  task automatic test_rw_same();
    logic [31:0] rd0, wr0;
    rd0 = m_rd; wr0 = m_wr;
    avmm_read = 1'b1; avmm_write = 1'b1; avmm_address = BASE + 64'd40;
    avmm_writedata = 64'hA5; avmm_byteenable = 8'hFF;
    step();
    idle();
    step();
    checks++; if (avmm_readdatavalid !== 1'b1 || avmm_readdata !== 64'hA5) begin
      errors++; $display("FAIL rw_same: got v=%0b d=%h expected v=1 d=a5", avmm_readdatavalid, avmm_readdata); end
    checks++; if (rd_count !== rd0 + 32'd1 || wr_count !== wr0 + 32'd1) begin
      errors++; $display("FAIL rw_same_counts: got rd=%0d wr=%0d expected %0d %0d", rd_count, wr_count, rd0 + 1, wr0 + 1); end
  endtask

  task automatic test_reset_flight();
    logic [63:0] keep;
    keep = ref_mem[9];
    avmm_read = 1'b1; avmm_address = BASE + 64'd72;
    step();
    avmm_read = 1'b0; reset = 1'b1;
    avmm_write = 1'b1; avmm_writedata = ~keep; avmm_byteenable = 8'hFF;
    step();
    reset = 1'b0; idle();
    checks++; if (avmm_readdatavalid !== 1'b0) begin errors++; $display("FAIL flight_valid: got %0b expected 0", avmm_readdatavalid); end
    checks++; if (rd_count !== 32'd0 || wr_count !== 32'd0) begin
      errors++; $display("FAIL flight_counts: got rd=%0d wr=%0d expected 0 0", rd_count, wr_count); end
    dbg_index = 10'd9;
    step();
    checks++; if (dbg_rdata !== keep) begin errors++; $display("FAIL flight_mem: got %h expected %h", dbg_rdata, keep); end
    step();
    checks++; if (avmm_readdatavalid !== 1'b0) begin errors++; $display("FAIL flight_late: got %0b expected 0", avmm_readdatavalid); end
  endtask

`ifdef AVMM_RESP_RANGE_CHECK_EN
  task automatic test_range();
    logic [63:0] keep;
    reset = 1'b1; idle(); step(); reset = 1'b0;
    keep = ref_mem[0];
    avmm_write = 1'b1; avmm_address = BASE + 64'h2000; avmm_writedata = ~keep; avmm_byteenable = 8'hFF;
    step();
    avmm_write = 1'b0; dbg_index = 10'd0;
    checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL range_set: got %0b expected 1", range_err); end
    step();
    checks++; if (dbg_rdata !== keep) begin errors++; $display("FAIL range_mem: got %h expected %h", dbg_rdata, keep); end
    avmm_read = 1'b1; avmm_address = BASE + 64'h4;
    step();
    avmm_read = 1'b0;
    step();
    checks++; if (avmm_readdatavalid !== 1'b1 || avmm_readdata !== 64'h0 || range_err !== 1'b1) begin
      errors++; $display("FAIL range_read: got v=%0b d=%h e=%0b expected v=1 d=0 e=1", avmm_readdatavalid, avmm_readdata, range_err); end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset           = ($urandom_range(63) == 0);
      avmm_read       = ($urandom_range(1) == 1);
      avmm_write      = ($urandom_range(9) < 4);
      avmm_byteenable = 8'($urandom);
      avmm_writedata  = {$urandom, $urandom};
      if ($urandom_range(15) == 0) avmm_address = {$urandom, $urandom};
      else avmm_address = BASE + 64'($urandom_range(15)) * 64'd8 +
                          (($urandom_range(7) == 0) ? 64'($urandom_range(7)) : 64'd0);
      dbg_we    = ($urandom_range(7) == 0);
      dbg_index = 10'($urandom_range(15));
      dbg_wdata = {$urandom, $urandom};
      step();
      checks++; if (avmm_readdatavalid !== exp_v || avmm_readdata !== m_rdata) begin
        errors++; $display("FAIL rand_read_%0d: got v=%0b d=%h expected v=%0b d=%h", n, avmm_readdatavalid, avmm_readdata, exp_v, m_rdata); end
      checks++; if (rd_count !== m_rd || wr_count !== m_wr || range_err !== m_err) begin
        errors++; $display("FAIL rand_stat_%0d: got rd=%0d wr=%0d e=%0b expected %0d %0d %0b", n, rd_count, wr_count, range_err, m_rd, m_wr, m_err); end
      checks++; if (dbg_rdata !== m_dbg) begin
        errors++; $display("FAIL rand_dbg_%0d: got %h expected %h", n, dbg_rdata, m_dbg); end
    end
    reset = 1'b0; idle();
    for (int n = 0; n < int'(LAT) + 1; n++) begin
      step();
      checks++; if (avmm_readdatavalid !== exp_v || avmm_readdata !== m_rdata) begin
        errors++; $display("FAIL rand_drain_%0d: got v=%0b d=%h expected v=%0b d=%h", n, avmm_readdatavalid, avmm_readdata, exp_v, m_rdata); end
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    reset = 1'b1; idle();
    avmm_address = '0; avmm_byteenable = '0; avmm_writedata = '0;
    dbg_index = '0; dbg_wdata = '0;
    m_rdata = '0; m_dbg = '0; m_rd = '0; m_wr = '0; m_err = 1'b0; exp_v = 1'b0;
    test_reset();
    preload();
    test_single_rw();
    test_byte_mask();
    test_burst();
    test_rw_same();
    test_reset_flight();
`ifdef AVMM_RESP_RANGE_CHECK_EN
    test_range();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
